// File: rtl/alu_srv_pkg.sv
// Shared types for the ALU request server.
//   op_e  : opcode encoding carried on req_op. Codes not listed are illegal.
//   rsp_t : one buffered response entry (result plus flags plus echoed tag).
// The tag field is sized to TAG_W_MAX. Instances zero-extend their narrower
// TAG_W tag into it, and synthesis trims the constant upper bits.
package alu_srv_pkg;

  localparam int TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef struct packed {
    logic [31:0]          result;
    logic                 cout;
    logic                 zero;
    logic                 err;
    logic [TAG_W_MAX-1:0] tag;
  } rsp_t;

endpackage

// File: rtl/alu_exec_stage.sv
// Combinational execute stage: decodes the opcode and computes result and flags.
//   a, b : 32-bit operands
//   op   : raw 3-bit opcode (illegal codes give err=1, result 0)
//   tag  : request tag, passed through
//   rsp  : complete response entry, ready to be written into the buffer
module alu_exec_stage
  import alu_srv_pkg::*;
(
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic [2:0]           op,
  input  logic [TAG_W_MAX-1:0] tag,
  output rsp_t                 rsp
);

  logic [32:0] sum;

  // NOTE: every output of this block gets a default before the case statement,
  // so no path through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    rsp     = '0;
    rsp.tag = tag;
    sum     = '0;
    case (op)
      OP_AND: rsp.result = a & b;
      OP_OR:  rsp.result = a | b;
      OP_ADD: begin
        sum                    = {1'b0, a} + {1'b0, b};
        {rsp.cout, rsp.result} = sum;
      end
      OP_SUB: begin
        // Two's-complement subtract. Carry out set means no borrow (a >= b).
        sum                    = {1'b0, a} + {1'b0, ~b} + 33'd1;
        {rsp.cout, rsp.result} = sum;
      end
      OP_SLT: rsp.result = {31'd0, $signed(a) < $signed(b)};
      default: rsp.err = 1'b1;
    endcase
    rsp.zero = (rsp.result == 32'd0);
  end

endmodule

// File: rtl/alu_req_server.sv
// Pipelined ALU request/response server.
//   req_valid/req_ready  : request handshake. Operands, opcode and tag are
//                          captured into stage S1 on transfer.
//   rsp_valid/rsp_ready  : response handshake. The head of an in-order
//                          FIFO_DEPTH-entry buffer drives rsp_*.
//   err_count            : number of accepted illegal-opcode requests (wraps).
// S1 feeds the execute stage. Its result is written into the buffer on the next
// edge. req_ready depends only on registered occupancy, so S1 always has a
// buffer slot to drain into.
module alu_req_server
  import alu_srv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic             s1_valid;
  logic [31:0]      s1_a, s1_b;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  rsp_t             exec_rsp;
  rsp_t             mem [FIFO_DEPTH];
  rsp_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             req_fire, push, pop;
  logic             unused_tag_bits;

  assign req_fire = req_valid && req_ready;
  assign push     = s1_valid;
  assign pop      = rsp_valid && rsp_ready;

  // Count S1 as occupied so that its write always has a slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, s1_valid};
  assign req_ready = occupancy < {1'b0, FULL};

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= req_fire;
      if (req_fire) begin
        s1_a   <= req_a;
        s1_b   <= req_b;
        s1_op  <= req_op;
        s1_tag <= req_tag;
      end
    end
  end

  alu_exec_stage u_exec (
    .a   (s1_a),
    .b   (s1_b),
    .op  (s1_op),
    .tag (TAG_W_MAX'(s1_tag)),
    .rsp (exec_rsp)
  );

  // NOTE: the storage array has no reset. Stale entries are never visible
  // because the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exec_rsp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (push && exec_rsp.err) err_count <= err_count + 16'd1;
    end
  end

  assign rsp_valid  = (count != '0);
  assign head       = rsp_valid ? mem[rd_ptr] : '0;
  assign rsp_result = head.result;
  assign rsp_cout   = head.cout;
  assign rsp_zero   = head.zero;
  assign rsp_err    = head.err;
  assign rsp_tag    = head.tag[TAG_W-1:0];
  assign unused_tag_bits = ^head.tag;

  // S1 must never find the buffer full without a simultaneous pop.
  assert property (@(posedge clk) disable iff (rst)
    !(s1_valid && count == FULL && !pop));

endmodule

// File: tb/tb_alu_req_server.sv
// Self-checking bench for alu_req_server: table-driven vectors plus
// hand-written backpressure and reset sequences, checked through a scoreboard.
module tb_alu_req_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_zero, rsp_err;
  logic [3:0]  rsp_tag;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  alu_req_server #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .err_count(err_count)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
    exp_t        exp;
  } stim_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        err;
  } vec_t;

  stim_t       stim [32];
  vec_t        vecs [13];
  exp_t        exp_next;
  exp_t        sb [$];
  exp_t        mon_e;
  logic [38:0] mon_cur, mon_exp, held_v;
  logic        held;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rsp = 0;
  int          acc, cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic on wide integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    exp_t        e;
    logic [63:0] s;
    e     = '0;
    e.tag = tag;
    s     = 64'(a) + 64'(b);
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: begin e.result = s[31:0]; e.cout = s[32]; end
      3'b110: begin e.result = a - b; e.cout = (a >= b); end
      3'b111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Monitor: evaluated on the falling edge, so handshake inputs and registered
  // outputs match what the DUT sees at the following rising edge.
  always @(negedge clk) begin
    mon_cur = {rsp_result, rsp_cout, rsp_zero, rsp_err, rsp_tag};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) check("rsp stable under backpressure", 64'(mon_cur), 64'(held_v));
      held   = rsp_valid && !rsp_ready;
      held_v = mon_cur;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          check("unexpected rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e   = sb.pop_front();
          mon_exp = mon_e;
          check($sformatf("rsp tag %0d", mon_e.tag), 64'(mon_cur), 64'(mon_exp));
        end
      end
      if (req_valid && req_ready) sb.push_back(exp_next);
    end
  end

  task automatic load(input int i);
    req_a    = stim[i].a;
    req_b    = stim[i].b;
    req_op   = stim[i].op;
    req_tag  = stim[i].tag;
    exp_next = stim[i].exp;
  endtask

  // Presents stim[first..last] back to back, advancing on each transfer.
  task automatic run_stream(input int first, input int last, input int max_cycles,
                            output int accepted, output int cycles);
    int  idx;
    logic a_now;
    idx    = first;
    cycles = 0;
    load(idx);
    req_valid = 1'b1;
    while (idx <= last && cycles < max_cycles) begin
      @(negedge clk);
      a_now = req_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (a_now) begin
        idx++;
        if (idx <= last) load(idx);
      end
    end
    req_valid = 1'b0;
    accepted  = idx - first;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] bp_ops [6];
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b000, 4'd1,  32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h0F0F_0000, 32'h0000_F0F0, 3'b001, 4'd2,  32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 4'd3,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 4'd4,  32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h2000_0000, 32'h1000_0000, 3'b110, 4'd5,  32'h1000_0000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0001, 32'h0000_0002, 3'b110, 4'd6,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0005, 32'h0000_0005, 3'b110, 4'd7,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 4'd8,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'd1,         32'd10,        3'b111, 4'd9,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'd10,        32'd1,         3'b111, 4'd10, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 4'd11, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'hDEAD_BEEF, 32'h1234_5678, 3'b011, 4'd12, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{32'hCAFE_F00D, 32'h8765_4321, 3'b100, 4'd13, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      stim[i].a   = vecs[i].a;
      stim[i].b   = vecs[i].b;
      stim[i].op  = vecs[i].op;
      stim[i].tag = vecs[i].tag;
      stim[i].exp = {vecs[i].result, vecs[i].cout, vecs[i].zero, vecs[i].err, vecs[i].tag};
    end
    bp_ops = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b101, 3'b001};
    for (int i = 0; i < 6; i++) begin
      stim[13+i].a   = 32'h9000_0000 + 32'(i) * 32'h1111;
      stim[13+i].b   = 32'h7000_0000 - 32'(i);
      stim[13+i].op  = bp_ops[i];
      stim[13+i].tag = 4'(i);
      stim[13+i].exp = model(stim[13+i].a, stim[13+i].b, stim[13+i].op, stim[13+i].tag);
    end
    for (int i = 0; i < 3; i++) begin
      stim[19+i].a   = 32'(i + 100);
      stim[19+i].b   = 32'd7;
      stim[19+i].op  = 3'b010;
      stim[19+i].tag = 4'(i + 7);
      stim[19+i].exp = model(stim[19+i].a, stim[19+i].b, stim[19+i].op, stim[19+i].tag);
    end

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; held = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0; exp_next = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp fields", 64'({rsp_result, rsp_cout, rsp_zero, rsp_err, rsp_tag}), 64'd0);
    check("reset err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single AND request: one-cycle latency from acceptance to rsp_valid.
    run_stream(0, 0, 10, acc, cyc);
    check("accept first request", 64'(acc), 64'd1);
    check("rsp_valid while in S1", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("rsp_valid one cycle after accept", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    drain();

    // Remaining table vectors, streamed at full rate.
    run_stream(1, 12, 40, acc, cyc);
    check("table accepted", 64'(acc), 64'd12);
    check("table cycles (1/cycle)", 64'(cyc), 64'd12);
    drain();
    check("err_count after two illegal", 64'(err_count), 64'd2);

    // Backpressure: only FIFO_DEPTH requests get in while rsp_ready is low.
    rsp_ready = 1'b0;
    n_rsp     = 0;
    run_stream(13, 18, 8, acc, cyc);
    check("accepted under backpressure", 64'(acc), 64'd4);
    check("req_ready when full", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    check("req_ready before first pop", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("req_ready after first pop", 64'(req_ready), 64'd1);
    run_stream(17, 18, 20, acc, cyc);
    check("remaining accepted", 64'(acc), 64'd2);
    drain();
    check("backpressure responses", 64'(n_rsp), 64'd6);
    check("err_count after stream", 64'(err_count), 64'd3);

    // Reset with three responses buffered.
    rsp_ready = 1'b0;
    run_stream(19, 21, 10, acc, cyc);
    check("pre-reset accepted", 64'(acc), 64'd3);
    @(posedge clk);
    #1;
    check("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid-reset rsp fields", 64'({rsp_result, rsp_cout, rsp_zero, rsp_err, rsp_tag}), 64'd0);
    check("mid-reset req_ready", 64'(req_ready), 64'd1);
    check("mid-reset err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    n_rsp     = 0;
    repeat (8) @(posedge clk);
    #1;
    check("no stale responses", 64'(n_rsp), 64'd0);
    check("post-reset rsp_valid", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
